sfifo_wconv_up: RTL

// Single-clock FIFO with parametrised write-to-read width up-conversion: packs RATIO narrow write lanes into one wide read word.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sfifo_wconv_up_if.sv | 45 ++++
 rtl/sfifo_sdp_ram.sv | 68 ++++++
 rtl/sfifo_wconv_up.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting FIFO: constant log2, lane-order
// encodings and parameter legality checks.
package fifo_pkg;

    localparam bit LANE_LSB_FIRST = 1'b1;
    localparam bit LANE_MSB_FIRST = 1'b0;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit ratio_legal(input int ratio);
        return (ratio >= 1) && (ratio <= 16) && ((ratio & (ratio - 1)) == 0);
    endfunction

endpackage

// File: rtl/sfifo_wconv_up_if.sv
// Bus bundle for sfifo_wconv_up: narrow write side, wide read side, status,
// error flags and pointer debug taps.
interface sfifo_wconv_up_if import fifo_pkg::*; #(
    parameter int WR_DATA_WIDTH  = 16,
    parameter int RATIO          = 4,
    parameter int RD_DEPTH_WIDTH = 9
) ();
    localparam int LW            = clog2(RATIO);
    localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO;

    // Handshake: a lane is taken on a rising edge with wr_en && !wr_full, a
    // word is popped with rd_en && !rd_empty; requests made while blocked are
    // dropped and raise the sticky overflow/underflow flags.
    logic [WR_DATA_WIDTH-1:0]     wr_data;
    logic                         wr_en;
    logic                         flush;
    logic                         wr_full;
    logic [RD_DEPTH_WIDTH+LW:0]   wr_water_level;
    logic                         almost_full;
    logic                         rd_en;
    logic [RD_DATA_WIDTH-1:0]     rd_data;
    logic                         rd_valid;
    logic                         rd_empty;
    logic [RD_DEPTH_WIDTH:0]      rd_water_level;
    logic                         almost_empty;
    logic                         overflow;
    logic                         underflow;
    logic                         clear_err;
    logic [RD_DEPTH_WIDTH:0]      dbg_wptr;
    logic [RD_DEPTH_WIDTH:0]      dbg_rptr;

    modport master (
        output wr_data, wr_en, flush, rd_en, clear_err,
        input  wr_full, wr_water_level, almost_full, rd_data, rd_valid,
               rd_empty, rd_water_level, almost_empty, overflow, underflow,
               dbg_wptr, dbg_rptr
    );

    modport slave (
        input  wr_data, wr_en, flush, rd_en, clear_err,
        output wr_full, wr_water_level, almost_full, rd_data, rd_valid,
               rd_empty, rd_water_level, almost_empty, overflow, underflow,
               dbg_wptr, dbg_rptr
    );
endinterface

// File: rtl/sfifo_sdp_ram.sv
// Simple dual-port RAM, one write and one read port, 1-cycle read with an
// optional extra output register. Read data holds between reads.
module sfifo_sdp_ram #(
    parameter int DW         = 64,
    parameter int AW         = 9,
    parameter bit OUTPUT_REG = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd1_d, rd1_q;
    logic          v1_d, v1_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rd1_d = rd1_q;
        v1_d  = re;
        if (re) rd1_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            v1_q  <= v1_d;
        end
    end

    if (OUTPUT_REG) begin : g_oreg
        logic [DW-1:0] rd2_d, rd2_q;
        logic          v2_d, v2_q;

        always_comb begin
            rd2_d = rd2_q;
            v2_d  = v1_q;
            if (v1_q) rd2_d = rd1_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                rd2_q <= rd2_d;
                v2_q  <= v2_d;
            end
        end

        assign rdata  = rd2_q;
        assign rvalid = v2_q;
    end else begin : g_noreg
        assign rdata  = rd1_q;
        assign rvalid = v1_q;
    end
endmodule

// File: rtl/sfifo_wconv_up.sv
// Single-clock FIFO packing RATIO narrow write lanes into one wide read word,
// with partial-word flush, sticky error flags and registered status.
module sfifo_wconv_up import fifo_pkg::*; #(
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RATIO            = 4,
    parameter int RD_DEPTH_WIDTH   = 9,
    parameter int ALMOST_FULL_NUM  = 508,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter bit OUTPUT_REG       = 1'b0,
    parameter bit LSB_FIRST        = LANE_LSB_FIRST
) (
    input logic              clk,
    input logic              rst_n,
    sfifo_wconv_up_if.slave  bus
);
    localparam int LW    = clog2(RATIO);
    localparam int PCW   = (LW > 0) ? LW : 1;
    localparam int RDW   = WR_DATA_WIDTH * RATIO;
    localparam int PW    = RD_DEPTH_WIDTH + 1;
    localparam int WLW   = RD_DEPTH_WIDTH + LW + 1;
    localparam logic [PW-1:0]  DEPTH_C   = PW'(1 << RD_DEPTH_WIDTH);
    localparam logic [PW-1:0]  AF_C      = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0]  AE_C      = PW'(ALMOST_EMPTY_NUM);
    localparam logic [PCW-1:0] LAST_SLOT = PCW'(RATIO - 1);

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("sfifo_wconv_up: RATIO must be a power of 2 in 1..16");
    end

    logic [RDW-1:0] pack_d, pack_q, pack_ins;
    logic [PCW-1:0] pack_cnt_d, pack_cnt_q;
    logic [PW-1:0]  wptr_d, wptr_q, rptr_d, rptr_q;
    logic [PW-1:0]  ram_count_d, ram_count_q;
    logic           wr_full_d, wr_full_q, af_d, af_q;
    logic           rd_empty_d, rd_empty_q, ae_d, ae_q;
    logic           ovf_d, ovf_q, udf_d, udf_q;
    logic           wr_acc, rd_acc, word_done, flush_pend, flush_drop, commit;
    int             lane_idx;

    always_comb begin
        wr_acc   = bus.wr_en && !wr_full_q;
        rd_acc   = bus.rd_en && !rd_empty_q;
        lane_idx = (LSB_FIRST == LANE_LSB_FIRST) ? int'(pack_cnt_q)
                                                 : RATIO - 1 - int'(pack_cnt_q);
        pack_ins = pack_q;
        if (wr_acc) pack_ins[lane_idx*WR_DATA_WIDTH +: WR_DATA_WIDTH] = bus.wr_data;

        // A lane accepted alongside flush joins the flushed word; if it
        // completes the word, the normal commit already covers the flush.
        word_done  = wr_acc && (pack_cnt_q == LAST_SLOT);
        flush_pend = bus.flush && !word_done && (wr_acc || (pack_cnt_q != '0));
        flush_drop = flush_pend && (ram_count_q == DEPTH_C);
        commit     = word_done || (flush_pend && !flush_drop);

        pack_d      = commit ? '0 : pack_ins;
        pack_cnt_d  = commit ? '0 : (wr_acc ? pack_cnt_q + 1'b1 : pack_cnt_q);
        wptr_d      = wptr_q + PW'(commit);
        rptr_d      = rptr_q + PW'(rd_acc);
        ram_count_d = ram_count_q + PW'(commit) - PW'(rd_acc);

        ovf_d = (bus.wr_en && wr_full_q) || flush_drop || (ovf_q && !bus.clear_err);
        udf_d = (bus.rd_en && rd_empty_q) || (udf_q && !bus.clear_err);

        wr_full_d  = (ram_count_d == DEPTH_C) && (pack_cnt_d == LAST_SLOT);
        af_d       = ram_count_d >= AF_C;
        rd_empty_d = ram_count_d == '0;
        ae_d       = ram_count_d <= AE_C;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_count_q <= '0;
            wr_full_q   <= 1'b0;
            af_q        <= 1'b0;
            rd_empty_q  <= 1'b1;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_count_q <= ram_count_d;
            wr_full_q   <= wr_full_d;
            af_q        <= af_d;
            rd_empty_q  <= rd_empty_d;
            ae_q        <= ae_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    logic [RDW-1:0] ram_rdata;
    logic           ram_rvalid;

    sfifo_sdp_ram #(
        .DW         (RDW),
        .AW         (RD_DEPTH_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (commit),
        .waddr  (wptr_q[RD_DEPTH_WIDTH-1:0]),
        .wdata  (pack_ins),
        .re     (rd_acc),
        .raddr  (rptr_q[RD_DEPTH_WIDTH-1:0]),
        .rdata  (ram_rdata),
        .rvalid (ram_rvalid)
    );

    assign bus.rd_data        = ram_rdata;
    assign bus.rd_valid       = ram_rvalid;
    assign bus.wr_full        = wr_full_q;
    assign bus.almost_full    = af_q;
    assign bus.rd_empty       = rd_empty_q;
    assign bus.almost_empty   = ae_q;
    assign bus.overflow       = ovf_q;
    assign bus.underflow      = udf_q;
    assign bus.rd_water_level = ram_count_q;
    assign bus.wr_water_level = (WLW'(ram_count_q) << LW) | WLW'(pack_cnt_q);
    assign bus.dbg_wptr       = wptr_q;
    assign bus.dbg_rptr       = rptr_q;
endmodule
